// File: rtl/aap_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, frame constants and field layout.
// The optional checksum trailer is enabled with the LOADER_CHECKSUM_EN macro.
package aap_loader_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [15:0] LOADER_MAGIC = 16'hAA50;

  // ADDR_LO carries address bits [15:0]; ADDR_HI supplies the bits above that.
  localparam int unsigned ADDR_LO_W = 16;
  localparam int unsigned LEN_W     = 16;

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    sum16 = a + b;
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Modulo-2^16 running sum of frame words with synchronous clear and compare against a trailer.
module loader_checksum
  import aap_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] word,
  input  logic [15:0] expected,
  output logic        match
);

  logic [15:0] sum_r;

  // Accumulator: cleared at frame start, adds each header/data word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_r <= 16'h0000;
    end else if (clear) begin
      sum_r <= 16'h0000;
    end else if (add) begin
      sum_r <= sum16(sum_r, word);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign match = (sum_r == expected);

endmodule

// File: rtl/instruction_loader.sv
// Streams framed instruction words into instruction memory while holding the core.
// Define LOADER_CHECKSUM_EN to require and verify a trailing checksum word.
module instruction_loader
  import aap_loader_pkg::*;
#(
  parameter int          ADDR_W = 20,
  parameter int          DATA_W = 16,
  parameter logic [15:0] MAGIC  = LOADER_MAGIC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] instruction_wr1,
  output logic [DATA_W-1:0] instruction_wr1_data,
  output logic              instruction_wr1_enable,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error
);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CSUM;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [2:0]               state_r;
  logic [2:0]               next_state_s;
  logic [ADDR_W-ADDR_LO_W-1:0] addr_hi_r;
  logic [ADDR_W-1:0]        addr_r;
  logic [LEN_W-1:0]         remain_r;
  logic [ADDR_W-1:0]        wr_addr_r;
  logic [DATA_W-1:0]        wr_data_r;
  logic                     wr_en_r;
  logic                     core_hold_r;
  logic                     load_done_r;
  logic                     load_error_r;
  logic                     xfer_s;

  assign in_ready = (state_r != ST_DONE);
  assign xfer_s   = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
  logic csum_clear_s;
  logic csum_add_s;
  logic csum_match_s;

  assign csum_clear_s = xfer_s && (state_r == ST_IDLE);
  assign csum_add_s   = xfer_s && ((state_r == ST_ADDR_HI) || (state_r == ST_ADDR_LO) ||
                                   (state_r == ST_LEN) || (state_r == ST_DATA));

  loader_checksum u_checksum (
    .clock    (clock),
    .reset    (reset),
    .clear    (csum_clear_s),
    .add      (csum_add_s),
    .word     (in_data[15:0]),
    .expected (in_data[15:0]),
    .match    (csum_match_s)
  );
`endif

  // Next-state logic: one state per transfer, DONE always returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && (in_data[15:0] == MAGIC)) next_state_s = ST_ADDR_HI;
        else                                    next_state_s = ST_IDLE;
      end
      ST_ADDR_HI: begin
        if (xfer_s) next_state_s = ST_ADDR_LO;
        else        next_state_s = ST_ADDR_HI;
      end
      ST_ADDR_LO: begin
        if (xfer_s) next_state_s = ST_LEN;
        else        next_state_s = ST_ADDR_LO;
      end
      ST_LEN: begin
        if (xfer_s && (in_data[15:0] == 16'h0000)) next_state_s = ST_AFTER_DATA;
        else if (xfer_s)                           next_state_s = ST_DATA;
        else                                       next_state_s = ST_LEN;
      end
      ST_DATA: begin
        if (xfer_s && (remain_r == 16'd1)) next_state_s = ST_AFTER_DATA;
        else                               next_state_s = ST_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer_s) next_state_s = ST_DONE;
        else        next_state_s = ST_CSUM;
      end
`endif
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      addr_hi_r    <= '0;
      addr_r       <= '0;
      remain_r     <= 16'h0000;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      wr_en_r      <= 1'b0;
      core_hold_r  <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      wr_en_r     <= 1'b0;
      load_done_r <= (next_state_s == ST_DONE);
      if (next_state_s == ST_DONE) begin
        core_hold_r <= 1'b0;
      end else if (xfer_s && (state_r == ST_IDLE) && (in_data[15:0] == MAGIC)) begin
        core_hold_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (xfer_s && (in_data[15:0] == MAGIC)) load_error_r <= 1'b0;
        end
        ST_ADDR_HI: begin
          if (xfer_s) addr_hi_r <= in_data[ADDR_W-ADDR_LO_W-1:0];
        end
        ST_ADDR_LO: begin
          if (xfer_s) addr_r <= {addr_hi_r, in_data[ADDR_LO_W-1:0]};
        end
        ST_LEN: begin
          if (xfer_s) remain_r <= in_data[LEN_W-1:0];
        end
        ST_DATA: begin
          if (xfer_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= addr_r;
            wr_data_r <= in_data;
            addr_r    <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            remain_r  <= remain_r - 16'd1;
            // A write at the top address followed by another word means the frame wraps.
            if ((&addr_r) && (remain_r != 16'd1)) load_error_r <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer_s && !csum_match_s) load_error_r <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign instruction_wr1        = wr_addr_r;
  assign instruction_wr1_data   = wr_data_r;
  assign instruction_wr1_enable = wr_en_r;
  assign core_hold              = core_hold_r;
  assign load_done              = load_done_r;
  assign load_error             = load_error_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader (default build or LOADER_CHECKSUM_EN).
module tb_instruction_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] instruction_wr1;
  logic [15:0] instruction_wr1_data;
  logic        instruction_wr1_enable;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int done_count = 0;

  instruction_loader dut (
    .clock                  (clock),
    .reset                  (reset),
    .in_data                (in_data),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .instruction_wr1        (instruction_wr1),
    .instruction_wr1_data   (instruction_wr1_data),
    .instruction_wr1_enable (instruction_wr1_enable),
    .core_hold              (core_hold),
    .load_done              (load_done),
    .load_error             (load_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (instruction_wr1_enable) wr_count++;
    if (load_done) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word and return #1 after the edge on which it was accepted.
  task automatic send(input logic [15:0] w);
    int tries;
    tries = 0;
    @(negedge clock);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && tries < 8) begin
      @(negedge clock);
      tries++;
    end
    if (tries >= 8) check("ready_timeout", 32'(tries), 32'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [19:0] a, input logic [15:0] d);
    check({tag, "_en"}, 32'(instruction_wr1_enable), 32'd1);
    check({tag, "_addr"}, 32'(instruction_wr1), 32'(a));
    check({tag, "_data"}, 32'(instruction_wr1_data), 32'(d));
  endtask

  // Final frame word: plain last word, or trailer in checksum builds. Checks the DONE cycle.
  task automatic finish_frame(input string tag, input logic [15:0] csum, input logic exp_err);
`ifdef LOADER_CHECKSUM_EN
    send(csum);
`endif
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_hold_drop"}, 32'(core_hold), 32'd0);
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    check({tag, "_err"}, 32'(load_error), 32'(exp_err));
    @(posedge clock);
    #1;
    check({tag, "_done_1cyc"}, 32'(load_done), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_hold", 32'(core_hold), 32'd0);
    check("rst_wen", 32'(instruction_wr1_enable), 32'd0);
    check("rst_addr", 32'(instruction_wr1), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    reset = 1'b1;

    // Basic frame: three words at 0x00010.. ; checksum 0x6679
    send(16'hAA50);
    check("f1_hold_up", 32'(core_hold), 32'd1);
    send(16'h0000); send(16'h0010); send(16'h0003);
    check("f1_hold_hdr", 32'(core_hold), 32'd1);
    send(16'h1111); check_write("f1_w0", 20'h00010, 16'h1111);
    send(16'h2222); check_write("f1_w1", 20'h00011, 16'h2222);
    send(16'h3333); check_write("f1_w2", 20'h00012, 16'h3333);
    finish_frame("f1", 16'h6679, 1'b0);
    settle();
    check("f1_wr_count", 32'(wr_count), 32'd3);
    check("f1_done_count", 32'(done_count), 32'd1);

    // Garbage word ignored in IDLE, then a normal one-word frame
    send(16'h1234);
    check("g_hold", 32'(core_hold), 32'd0);
    check("g_ready", 32'(in_ready), 32'd1);
    check("g_wen", 32'(instruction_wr1_enable), 32'd0);
    send(16'hAA50); send(16'h0000); send(16'h0020); send(16'h0001);
    send(16'hBEEF); check_write("g_w0", 20'h00020, 16'hBEEF);
    finish_frame("g", 16'hBF10, 1'b0);
    settle();
    check("g_wr_count", 32'(wr_count), 32'd4);

    // Address wrap: writes at 0xFFFFF then 0x00000, error flagged
    send(16'hAA50); send(16'h000F); send(16'hFFFF); send(16'h0002);
    send(16'h000A); check_write("wr_w0", 20'hFFFFF, 16'h000A);
    send(16'h000B); check_write("wr_w1", 20'h00000, 16'h000B);
    finish_frame("wr", 16'h0025, 1'b1);
    settle();
    check("wr_err_sticky", 32'(load_error), 32'd1);
    check("wr_wr_count", 32'(wr_count), 32'd6);

    // LEN = 0: no writes; next MAGIC clears the sticky error
    send(16'hAA50);
    check("l0_err_clr", 32'(load_error), 32'd0);
    check("l0_hold_up", 32'(core_hold), 32'd1);
    send(16'h0000); send(16'h0030); send(16'h0000);
`ifdef LOADER_CHECKSUM_EN
    check("l0_hold_csum", 32'(core_hold), 32'd1);
`endif
    finish_frame("l0", 16'h0030, 1'b0);
    settle();
    check("l0_wr_count", 32'(wr_count), 32'd6);
    check("l0_done_count", 32'(done_count), 32'd4);
    check("l0_hold_after", 32'(core_hold), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailer still completes but flags an error
    send(16'hAA50); send(16'h0000); send(16'h0010); send(16'h0003);
    send(16'h1111); send(16'h2222); send(16'h3333);
    finish_frame("bad", 16'h6678, 1'b1);
    settle();
    check("bad_wr_count", 32'(wr_count), 32'd9);
`endif

    // Reset after two of three data words: no third write
    send(16'hAA50); send(16'h0000); send(16'h0040); send(16'h0003);
    send(16'h0001); send(16'h0002); check_write("rs_w1", 20'h00041, 16'h0002);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rs_ready", 32'(in_ready), 32'd1);
    check("rs_hold", 32'(core_hold), 32'd0);
    check("rs_wen", 32'(instruction_wr1_enable), 32'd0);
    check("rs_addr", 32'(instruction_wr1), 32'd0);
    check("rs_data", 32'(instruction_wr1_data), 32'd0);
    check("rs_err", 32'(load_error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    send(16'h0003);
    check("rs_no_w3", 32'(instruction_wr1_enable), 32'd0);
    settle();
    check("rs_hold_after", 32'(core_hold), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rs_wr_count", 32'(wr_count), 32'd11);
`else
    check("rs_wr_count", 32'(wr_count), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
